// File: rtl/reg_fifo_pkg.sv
// reg_fifo_pkg: shared defaults and sizing helpers for reg_fifo
package reg_fifo_pkg;
  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_DEPTH = 4;
  function automatic int cnt_bits(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic bit is_pow2(input int n);
    return n >= 2 && (n & (n - 1)) == 0;
  endfunction
endpackage

// File: rtl/reg_fifo_mem.sv
// reg_fifo_mem: DEPTH x WIDTH register array, clk/we/wr_addr/wr_data write, async rd_addr->rd_data read, no reset
module reg_fifo_mem
  import reg_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/reg_fifo.sv
// reg_fifo: fall-through FIFO, push enable/d, pop q/q_valid/q_ready, status full/count/sticky overflow, async rst_n
module reg_fifo
  import reg_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [WIDTH-1:0]            d,
  output logic [WIDTH-1:0]            q,
  output logic                        q_valid,
  input  logic                        q_ready,
  output logic                        full,
  output logic [cnt_bits(DEPTH)-1:0]  count,
  output logic                        overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_bits(DEPTH);
  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("reg_fifo: DEPTH must be a power of two and at least 2");
  end
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rd_data;
  logic push, pop;
  assign full = cnt == CW'(DEPTH);
  assign q_valid = cnt != '0;
  assign count = cnt;
  assign push = enable && !full;
  assign pop = q_ready && q_valid;
  assign q = q_valid ? rd_data : '0;
  reg_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .we(push),
    .wr_addr(wr_ptr),
    .wr_data(d),
    .rd_addr(rd_ptr),
    .rd_data(rd_data)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
      if (enable && full) overflow <= 1'b1;
    end
endmodule

// File: tb/tb_reg_fifo.sv
// tb_reg_fifo: scoreboard bench for reg_fifo, directed pushes queue expected words, negedge monitor checks pops
module tb_reg_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic [3:0] d = '0;
  logic q_ready = 1'b0;
  logic [3:0] q;
  logic q_valid, full, overflow;
  logic [2:0] count;
  int checks = 0;
  int errors = 0;
  logic [3:0] expq [$];
  reg_fifo #(.WIDTH(4), .DEPTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .d(d),
    .q(q),
    .q_valid(q_valid),
    .q_ready(q_ready),
    .full(full),
    .count(count),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (rst_n && q_valid && q_ready) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected got=%h required=none", q);
      end else begin
        logic [3:0] e;
        e = expq.pop_front();
        if (q !== e) begin
          errors++;
          $display("FAIL pop_data got=%h required=%h", q, e);
        end
      end
    end
  task automatic chk(input string n, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", n, got, exp);
    end
  endtask
  task automatic step(input logic en, input logic [3:0] dv, input logic rdy, input logic exp_push);
    enable = en;
    d = dv;
    q_ready = rdy;
    if (exp_push) expq.push_back(dv);
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_count", 8'(count), 8'd0);
    chk("rst_valid", 8'(q_valid), 8'd0);
    chk("rst_q", 8'(q), 8'd0);
    chk("rst_full", 8'(full), 8'd0);
    chk("rst_ovf", 8'(overflow), 8'd0);
    step(1, 4'h1, 0, 1);
    chk("lat_q", 8'(q), 8'h1);
    chk("lat_valid", 8'(q_valid), 8'd1);
    step(1, 4'h2, 0, 1);
    step(1, 4'h3, 0, 1);
    chk("order_count", 8'(count), 8'd3);
    for (int i = 0; i < 3; i++) step(0, 4'h0, 1, 0);
    chk("drain_valid", 8'(q_valid), 8'd0);
    chk("drain_q", 8'(q), 8'd0);
    step(1, 4'hA, 0, 1);
    step(1, 4'hB, 0, 1);
    step(1, 4'hC, 0, 1);
    step(1, 4'hD, 0, 1);
    chk("full_flag", 8'(full), 8'd1);
    chk("full_count", 8'(count), 8'd4);
    chk("full_ovf0", 8'(overflow), 8'd0);
    step(1, 4'hE, 0, 0);
    chk("ovf_count", 8'(count), 8'd4);
    chk("ovf_set", 8'(overflow), 8'd1);
    for (int i = 0; i < 4; i++) step(0, 4'h0, 1, 0);
    chk("ovf_drain_count", 8'(count), 8'd0);
    chk("ovf_sticky", 8'(overflow), 8'd1);
    step(1, 4'h5, 0, 1);
    step(1, 4'h6, 0, 1);
    step(1, 4'h7, 1, 1);
    chk("pp_count", 8'(count), 8'd2);
    chk("pp_q", 8'(q), 8'h6);
    step(1, 4'h8, 0, 1);
    step(1, 4'h9, 0, 1);
    chk("pp_full", 8'(full), 8'd1);
    step(1, 4'hF, 1, 0);
    chk("ppfull_count", 8'(count), 8'd3);
    chk("ppfull_ovf", 8'(overflow), 8'd1);
    for (int i = 0; i < 3; i++) step(0, 4'h0, 1, 0);
    chk("pp_drain_count", 8'(count), 8'd0);
    step(1, 4'h1, 0, 1);
    step(1, 4'h2, 0, 1);
    #2;
    enable = 1'b1;
    d = 4'hF;
    q_ready = 1'b0;
    rst_n = 1'b0;
    expq.delete();
    #1;
    chk("arst_q", 8'(q), 8'd0);
    chk("arst_valid", 8'(q_valid), 8'd0);
    chk("arst_count", 8'(count), 8'd0);
    chk("arst_ovf", 8'(overflow), 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    enable = 1'b0;
    chk("arst_nowrite", 8'(count), 8'd0);
    step(1, 4'h3, 0, 1);
    chk("post_rst_q", 8'(q), 8'h3);
    chk("post_rst_count", 8'(count), 8'd1);
    step(0, 4'h0, 1, 0);
    step(1, 4'h0, 0, 1);
    for (int i = 1; i < 10; i++) begin
      step(1, 4'(i), 1, 1);
      chk("wrap_count", 8'(count), 8'd1);
    end
    step(0, 4'h0, 1, 0);
    chk("wrap_empty", 8'(count), 8'd0);
    chk("wrap_ovf", 8'(overflow), 8'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 4'h0, 1, 0);
      chk("rd_empty_count", 8'(count), 8'd0);
      chk("rd_empty_valid", 8'(q_valid), 8'd0);
    end
    step(1, 4'h8, 1, 1);
    chk("we_q", 8'(q), 8'h8);
    chk("we_count", 8'(count), 8'd1);
    step(0, 4'h0, 1, 0);
    chk("we_pop_count", 8'(count), 8'd0);
    step(0, 4'h0, 0, 0);
    chk("sb_empty", 8'(expq.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_fifo.md
# reg_fifo

Small register-bank FIFO that is the consumer-side counterpart of the enable-loaded `Register`. Producers write words with the same `enable`/`d` strobe. A downstream reader drains the words in order through a `q_valid`/`q_ready` handshake. Typical uses on the Basys3 board are buffering switch- or button-sampled nibbles between a producer and a slower display or UART consumer.

## Interface
Parameters:
- `WIDTH`, 4: data word width in bits.
- `DEPTH`, 4: number of entries. Must be a power of two and at least 2.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: write strobe; `d` is pushed on the rising edge when the FIFO is not full.
- `d` in WIDTH: write data.
- `q` out WIDTH: head-of-queue word; 0 when `q_valid` = 0.
- `q_valid` out 1: the FIFO holds at least one word.
- `q_ready` in 1: reader accepts `q` on the rising edge when `q_valid` = 1.
- `full` out 1: `count` == DEPTH.
- `count` out $clog2(DEPTH+1): number of stored words.
- `overflow` out 1: sticky flag, set by a write attempted while `full`.

## Operation
- **Storage:** DEPTH x WIDTH registers, plus write pointer `wr_ptr` and read pointer `rd_ptr`, each $clog2(DEPTH) bits. Both pointers wrap modulo DEPTH naturally. `count` is kept as a separate register.
- **Push:** occurs when `enable` && !`full`. Writes `mem[wr_ptr]` <= `d` and increments `wr_ptr`.
- **Pop:** occurs when `q_ready` && `q_valid`. Increments `rd_ptr`.
- **Count update:**
  - Push only: `count`+1.
  - Pop only: `count`-1.
  - Push and pop together: unchanged.
- **Full, write rejected:** `enable` while `full` does not push, even if a pop happens in the same cycle. Data is dropped and `overflow` <= 1.
- **Empty, read ignored:** `q_ready` while empty is ignored. Nothing changes and there is no underflow flag.
- **Write while empty:** `enable` with `q_ready` = 1 while empty pushes only. The reader sees the word on the next cycle.
- **Reset (`rst_n` = 0):** asynchronously clears `wr_ptr`, `rd_ptr`, `count` and `overflow`. Resulting outputs are `q` = 0, `q_valid` = 0, `full` = 0, `count` = 0, `overflow` = 0. Memory contents need not be cleared; they are unobservable because `q` is masked when empty.
- **Reset mid-operation:** discards all stored words. The first write after `rst_n` rises lands in entry 0.
- **Overflow clearing:** `overflow` is cleared only by reset.

## Timing
- **Write-to-read latency:** one cycle. A word pushed on edge N drives `q` and `q_valid` = 1 from just after edge N.
- **Head word:** `q` = `mem[rd_ptr]` is combinational from registered state (first-word fall-through). No other input-to-output combinational path exists.
- **Pop-to-next-word:** after a pop on edge N, `q` shows the next word, or drops to 0 if the FIFO became empty, just after edge N.
- **Flag timing:** `full`, `q_valid` and `count` are all decoded from registered `count` and change only on a rising edge or on reset assertion.
- **Throughput:** one push and one pop per cycle, sustained.

## Structure
- **Package `reg_fifo_pkg`:**
  - `DEFAULT_WIDTH` = 4 and `DEFAULT_DEPTH` = 4.
  - Function `cnt_bits(depth)` returning $clog2(depth+1).
  - Compile-time check that DEPTH is a power of two.
- **Sub-module `reg_fifo_mem`:** a DEPTH x WIDTH register array. It takes `clk`, a write enable, `wr_addr`, `wr_data` and `rd_addr`, and gives an asynchronous read. It has no reset. The top level holds the pointers, count, flags and masking.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-cycle with `enable` = 1 and `d` = 4'hf -> `q` = 0, `q_valid` = 0, `count` = 0, `overflow` = 0 immediately (asynchronous). No write occurs.
- **Order and latency:** push 4'h1, 4'h2, 4'h3 on three consecutive edges with `q_ready` = 0 -> `q` = 4'h1 and `q_valid` = 1 one cycle after the first edge; `count` = 3. Then hold `q_ready` = 1 -> `q` shows 4'h2, then 4'h3, then 0 with `q_valid` = 0.
- **Full and overflow:** push 4'hA, 4'hB, 4'hC, 4'hD -> `full` = 1, `count` = 4. Push 4'hE -> `count` stays 4 and `overflow` = 1 (sticky). Drain -> A, B, C, D come out and 4'hE never appears.
- **Simultaneous push/pop:**
  - With `count` = 2 (4'h5, 4'h6), assert `enable` with `d` = 4'h7 and `q_ready` = 1 for one edge -> `count` = 2, `q` = 4'h6.
  - At `full`, `enable` plus `q_ready` -> `count` = 3 and `overflow` = 1.
- **Pointer wrap-around:** push and pop 10 words 4'h0..4'h9 in a streaming pattern -> every word emerges in order, `count` never exceeds 4, and `overflow` stays 0.
- **Read while empty:** `q_ready` = 1 for 3 cycles on an empty FIFO -> no state change and `count` = 0. Then push 4'h8 -> `q` = 4'h8 on the next cycle and is popped on the following edge.
